dispatch_buffer: RTL and testbench
==================================

DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of 4-instruction group entries (power of two, >=2).
REQ-002 SHALL have parameters WIDTH_REG=5, WIDTH_TAG=5, WIDTH_BRM=3, meaning register, tag and branch-mask field widths.
REQ-003 SHALL have parameter WIDTH, default 7+WIDTH_BRM+WIDTH_TAG+3*WIDTH_REG+3, meaning instruction word width.
REQ-004 SHALL have i_clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have i_inst1..i_inst4  input  WIDTH each  renamed instruction group from rename stage.
REQ-007 SHALL have i_valid  input  1  rename stage presents a group this cycle.
REQ-008 SHALL have o_ready  output  1  buffer accepts a group this cycle.
REQ-009 SHALL have o_inst1..o_inst4  output  WIDTH each  head group, driven into issue-queue slot inputs.
REQ-010 SHALL have o_en  output  1  issue-queue shift enable; head group consumed this cycle.
REQ-011 SHALL have i_stall  input  1  issue queue cannot accept a group this cycle.
REQ-012 SHALL have i_BrKill  input  WIDTH_BRM  mispredicted-branch mask, same encoding as issue slots.
REQ-013 SHALL have i_flush  input  1  discard all buffered groups.

Function
REQ-014 Instruction bit 0 SHALL be the valid bit; bits [WIDTH_BRM:1] SHALL be the branch mask.
REQ-015 Storage SHALL be a circular FIFO of DEPTH groups with write pointer, read pointer (modulo DEPTH, wrap DEPTH-1 -> 0) and count of $clog2(DEPTH)+1 bits.
REQ-016 o_ready SHALL be 1 iff count < DEPTH; no push-through-when-full.
REQ-017 Push SHALL occur iff i_valid & o_ready & ~i_flush; group written at write pointer, pointer incremented.
REQ-018 o_en SHALL be 1 iff count != 0 & ~i_stall & ~i_flush; pop advances read pointer on that edge.
REQ-019 o_inst1..4 SHALL equal the head entry combinationally when count != 0, else all-zero.
REQ-020 Push-to-output latency SHALL be one cycle; no empty bypass.
REQ-021 Simultaneous push and pop SHALL leave count unchanged.
REQ-022 Every stored instruction whose (branch mask & i_BrKill) != 0 SHALL have its valid bit cleared at the edge; other fields unchanged.
REQ-023 An instruction pushed in the same cycle as a matching i_BrKill SHALL be stored with valid bit cleared.
REQ-024 Groups with all valid bits clear SHALL remain in the FIFO and pop normally as bubbles.
REQ-025 Kill SHALL apply to the head group in the same cycle it pops only via the combinational outputs: o_inst valid bits SHALL be masked by the current i_BrKill.
REQ-026 i_flush SHALL zero count and both pointers at the edge and take priority over push, pop and kill.

Reset
REQ-027 On i_rst_n low, count and pointers SHALL be 0 immediately; o_ready=1, o_en=0, o_inst1..4=0.
REQ-028 Storage contents SHALL not require reset; visibility is gated by count.
REQ-029 Reset mid-operation SHALL discard all groups; first push after release appears at outputs one cycle later.

Structure
REQ-030 Bit positions of valid bit and branch-mask field SHALL be defines in the shared instruction-format include used by issue_slot.
REQ-031 One sub-module dispatch_entry (one group register with per-instruction kill logic) SHALL be instantiated DEPTH times.

Verification
REQ-032 Push groups A,B,C,D with i_stall=1 -> o_ready=0 after fourth push, count=4; fifth i_valid ignored.
REQ-033 From full, i_stall=0 for 4 cycles -> o_en=1 each cycle, outputs A,B,C,D in order, then all-zero and o_en=0.
REQ-034 Push and pop every cycle for 10 cycles with DEPTH=4 -> pointers wrap, count steady at 1, order preserved.
REQ-035 Stored instructions with brmask 3'b010 and 3'b100, i_BrKill=3'b010 -> only first loses valid bit; group still pops.
REQ-036 i_flush with i_valid=1 and count=3 -> count=0, push rejected, o_en=0 next cycle.
REQ-037 i_rst_n low mid-stream with count=2 -> o_inst=0, o_ready=1 immediately, without clock edge.

Source files
------------

// File: rtl/dispatch_buffer_pkg.sv
// Shared instruction-format constants for the dispatch buffer and issue slots.
package dispatch_buffer_pkg;

  localparam int GROUP_SIZE = 4;
  localparam int VALID_BIT  = 0;
  localparam int BRM_LSB    = 1;

endpackage

// File: rtl/dispatch_entry.sv
// One buffered instruction group with per-instruction branch-kill handling.
module dispatch_entry
  import dispatch_buffer_pkg::*;
#(
  parameter int WIDTH     = 33,
  parameter int WIDTH_BRM = 3
) (
  input  logic                               i_clk,
  input  logic                               i_we,
  input  logic [GROUP_SIZE-1:0][WIDTH-1:0]   i_grp,
  input  logic [WIDTH_BRM-1:0]               i_BrKill,
  output logic [GROUP_SIZE-1:0][WIDTH-1:0]   o_view
);

  logic [GROUP_SIZE-1:0][WIDTH-1:0] grp_q;

  function automatic logic [WIDTH-1:0] apply_kill(input logic [WIDTH-1:0] inst,
                                                  input logic [WIDTH_BRM-1:0] kill);
    logic [WIDTH-1:0] res;
    res = inst;
    if ((inst[BRM_LSB +: WIDTH_BRM] & kill) != '0) res[VALID_BIT] = 1'b0;
    return res;
  endfunction

  // Kill applies to both the incoming group and the held group on every edge.
  always_ff @(posedge i_clk) begin
    for (int g = 0; g < GROUP_SIZE; g++) begin
      grp_q[g] <= apply_kill(i_we ? i_grp[g] : grp_q[g], i_BrKill);
    end
  end

  // Same-cycle view so a head group popping under a kill leaves with valid cleared.
  always_comb begin
    o_view = '0;
    for (int g = 0; g < GROUP_SIZE; g++) begin
      o_view[g] = apply_kill(grp_q[g], i_BrKill);
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular FIFO of renamed 4-instruction groups feeding the issue queue.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_inst1,
  input  logic [WIDTH-1:0]     i_inst2,
  input  logic [WIDTH-1:0]     i_inst3,
  input  logic [WIDTH-1:0]     i_inst4,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [WIDTH-1:0]     o_inst1,
  output logic [WIDTH-1:0]     o_inst2,
  output logic [WIDTH-1:0]     o_inst3,
  output logic [WIDTH-1:0]     o_inst4,
  output logic                 o_en,
  input  logic                 i_stall,
  input  logic [WIDTH_BRM-1:0] i_BrKill,
  input  logic                 i_flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  logic [GROUP_SIZE-1:0][WIDTH-1:0] in_grp, head;
  logic [GROUP_SIZE-1:0][WIDTH-1:0] view [DEPTH];

  assign in_grp  = {i_inst4, i_inst3, i_inst2, i_inst1};
  assign o_ready = (count < FULL);
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = (count != '0) & ~i_stall & ~i_flush;
  assign o_en    = pop;

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    dispatch_entry #(
      .WIDTH     (WIDTH),
      .WIDTH_BRM (WIDTH_BRM)
    ) u_entry (
      .i_clk    (i_clk),
      .i_we     (push && (wr_ptr == PTR_W'(e))),
      .i_grp    (in_grp),
      .i_BrKill (i_BrKill),
      .o_view   (view[e])
    );
  end

  // Storage is never reset, so the count alone decides whether the head is visible.
  assign head = (count != '0) ? view[rd_ptr] : '0;
  assign {o_inst4, o_inst3, o_inst2, o_inst1} = head;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed self-checking bench for dispatch_buffer (DEPTH=4, 33-bit instructions).
module tb_dispatch_buffer;

  localparam int W   = 33;
  localparam int PW  = W - 4;
  localparam int GW  = 4 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  i_inst1, i_inst2, i_inst3, i_inst4;
  logic          i_valid, i_stall, i_flush;
  logic [2:0]    i_BrKill;
  logic          o_ready, o_en;
  logic [W-1:0]  o_inst1, o_inst2, o_inst3, o_inst4;
  logic [GW-1:0] grp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dispatch_buffer dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_inst1  (i_inst1),
    .i_inst2  (i_inst2),
    .i_inst3  (i_inst3),
    .i_inst4  (i_inst4),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_inst1  (o_inst1),
    .o_inst2  (o_inst2),
    .o_inst3  (o_inst3),
    .o_inst4  (o_inst4),
    .o_en     (o_en),
    .i_stall  (i_stall),
    .i_BrKill (i_BrKill),
    .i_flush  (i_flush)
  );

  assign grp_out = {o_inst4, o_inst3, o_inst2, o_inst1};

  function automatic logic [W-1:0] mk(input int pay, input logic [2:0] brm, input logic v);
    return {PW'(pay), brm, v};
  endfunction

  function automatic logic [GW-1:0] grp(input int base);
    return {mk(base + 3, 3'b000, 1'b1), mk(base + 2, 3'b000, 1'b1),
            mk(base + 1, 3'b000, 1'b1), mk(base, 3'b000, 1'b1)};
  endfunction

  task automatic drive(input logic [GW-1:0] g);
    {i_inst4, i_inst3, i_inst2, i_inst1} = g;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_BrKill = 3'b000;
    drive(grp(7));
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_en !== 1'b0 || grp_out !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%b en=%b out=%h required ready=1 en=0 out=0", o_ready, o_en, grp_out);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_en !== 1'b0 || grp_out !== '0) begin
      errors++;
      $display("FAIL reset_release ready=%b en=%b out=%h required ready=1 en=0 out=0", o_ready, o_en, grp_out);
    end
    step();
  endtask

  task automatic test_fill;
    i_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(grp(100 * (k + 1)));
      i_valid = 1'b1;
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready push=%0d got=%b required=1", k, o_ready);
      end
      step();
    end
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_en !== 1'b0 || grp_out !== grp(100)) begin
      errors++;
      $display("FAIL fill_full ready=%b en=%b out=%h required ready=0 en=0 out=%h", o_ready, o_en, grp_out, grp(100));
    end
    drive(grp(500));
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  task automatic test_drain;
    i_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (o_en !== 1'b1 || grp_out !== grp(100 * (k + 1))) begin
        errors++;
        $display("FAIL drain_order pop=%0d en=%b out=%h required en=1 out=%h", k, o_en, grp_out, grp(100 * (k + 1)));
      end
      step();
    end
    #1;
    checks++;
    if (o_en !== 1'b0 || grp_out !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty en=%b ready=%b out=%h required en=0 ready=1 out=0", o_en, o_ready, grp_out);
    end
  endtask

  task automatic test_back_to_back;
    i_stall = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      drive(grp(1000 + 10 * k));
      #1;
      checks++;
      if (k == 0) begin
        if (o_en !== 1'b0 || grp_out !== '0) begin
          errors++;
          $display("FAIL b2b_first en=%b out=%h required en=0 out=0", o_en, grp_out);
        end
      end else if (o_en !== 1'b1 || o_ready !== 1'b1 || grp_out !== grp(1000 + 10 * (k - 1))) begin
        errors++;
        $display("FAIL b2b_cycle k=%0d en=%b ready=%b out=%h required en=1 ready=1 out=%h",
                 k, o_en, o_ready, grp_out, grp(1000 + 10 * (k - 1)));
      end
      step();
    end
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b1 || grp_out !== grp(1100)) begin
      errors++;
      $display("FAIL b2b_last en=%b out=%h required en=1 out=%h", o_en, grp_out, grp(1100));
    end
    step();
    #1;
    checks++;
    if (o_en !== 1'b0 || grp_out !== '0) begin
      errors++;
      $display("FAIL b2b_empty en=%b out=%h required en=0 out=0", o_en, grp_out);
    end
  endtask

  task automatic test_kill;
    logic [GW-1:0] k1, k1x, k2, k2x;
    k1  = {mk(24, 3'b011, 1'b1), mk(23, 3'b000, 1'b1), mk(22, 3'b100, 1'b1), mk(21, 3'b010, 1'b1)};
    k1x = {mk(24, 3'b011, 1'b0), mk(23, 3'b000, 1'b1), mk(22, 3'b100, 1'b1), mk(21, 3'b010, 1'b0)};
    k2  = {mk(34, 3'b010, 1'b1), mk(33, 3'b010, 1'b1), mk(32, 3'b010, 1'b1), mk(31, 3'b010, 1'b1)};
    k2x = {mk(34, 3'b010, 1'b0), mk(33, 3'b010, 1'b0), mk(32, 3'b010, 1'b0), mk(31, 3'b010, 1'b0)};
    i_stall = 1'b1;
    drive(k1);
    i_valid = 1'b1;
    step();
    drive(k2);
    i_BrKill = 3'b010;
    #1;
    checks++;
    if (grp_out !== k1x) begin
      errors++;
      $display("FAIL kill_comb out=%h required %h", grp_out, k1x);
    end
    step();
    i_valid = 1'b0;
    i_BrKill = 3'b000;
    #1;
    checks++;
    if (grp_out !== k1x) begin
      errors++;
      $display("FAIL kill_stored out=%h required %h", grp_out, k1x);
    end
    i_stall = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b1) begin
      errors++;
      $display("FAIL kill_pop en=%b required 1", o_en);
    end
    step();
    #1;
    checks++;
    if (o_en !== 1'b1 || grp_out !== k2x) begin
      errors++;
      $display("FAIL kill_bubble en=%b out=%h required en=1 out=%h", o_en, grp_out, k2x);
    end
    step();
    #1;
    checks++;
    if (o_en !== 1'b0 || grp_out !== '0) begin
      errors++;
      $display("FAIL kill_empty en=%b out=%h required en=0 out=0", o_en, grp_out);
    end
  endtask

  task automatic test_flush;
    i_stall = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(grp(2000 + 10 * k));
      step();
    end
    drive(grp(2500));
    i_flush = 1'b1;
    i_stall = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b0 || grp_out !== grp(2000)) begin
      errors++;
      $display("FAIL flush_comb en=%b out=%h required en=0 out=%h", o_en, grp_out, grp(2000));
    end
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b0 || o_ready !== 1'b1 || grp_out !== '0) begin
      errors++;
      $display("FAIL flush_after en=%b ready=%b out=%h required en=0 ready=1 out=0", o_en, o_ready, grp_out);
    end
    drive(grp(3000));
    i_valid = 1'b1;
    #1;
    checks++;
    if (grp_out !== '0) begin
      errors++;
      $display("FAIL flush_no_bypass out=%h required 0", grp_out);
    end
    step();
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b1 || grp_out !== grp(3000)) begin
      errors++;
      $display("FAIL flush_repush en=%b out=%h required en=1 out=%h", o_en, grp_out, grp(3000));
    end
    step();
  endtask

  task automatic test_async_reset;
    i_stall = 1'b1;
    i_valid = 1'b1;
    drive(grp(4000)); step();
    drive(grp(4100)); step();
    i_valid = 1'b0;
    i_stall = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b1 || grp_out !== grp(4000)) begin
      errors++;
      $display("FAIL areset_pre en=%b out=%h required en=1 out=%h", o_en, grp_out, grp(4000));
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b0 || o_ready !== 1'b1 || grp_out !== '0) begin
      errors++;
      $display("FAIL areset_immediate en=%b ready=%b out=%h required en=0 ready=1 out=0", o_en, o_ready, grp_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(grp(4200));
    i_valid = 1'b1;
    #1;
    checks++;
    if (grp_out !== '0) begin
      errors++;
      $display("FAIL areset_release out=%h required 0", grp_out);
    end
    step();
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b1 || grp_out !== grp(4200)) begin
      errors++;
      $display("FAIL areset_first_push en=%b out=%h required en=1 out=%h", o_en, grp_out, grp(4200));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_kill();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
